// File: rtl/stream_demux_ctrl_pkg.sv
// Shared defaults, counter-width helper and FSM state type for the stream demux credit controller.
package stream_demux_ctrl_pkg;

   localparam int DEF_N_OUP           = 3;
   localparam int DEF_MAX_OUTSTANDING = 4;

   function automatic int cnt_width(input int max_outstanding);
      return $clog2(max_outstanding + 1);
   endfunction

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/stream_demux_credit_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
   parameter int N     = 3,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic [SEL_W-1:0] gnt_idx_o,
   output logic             gnt_vld_o
);

   logic [SEL_W:0] cand;

   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = ptr_i;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr_i} + (SEL_W+1)'(i);
         if (cand >= (SEL_W+1)'(N)) cand = cand - (SEL_W+1)'(N);
         if (!gnt_vld_o && req_i[cand[SEL_W-1:0]]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = cand[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/stream_demux_credit_ctrl.sv
// Credit-aware round-robin steering for a stream demux; zero-latency ready path,
// a stalled grant is locked until accepted, full outputs are skipped.
module stream_demux_credit_ctrl
   import stream_demux_ctrl_pkg::*;
#(
   parameter int  N_OUP           = DEF_N_OUP,
   parameter int  MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   localparam int SEL_W           = $clog2(N_OUP),
   localparam int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     inp_valid_i,
   output logic                     inp_ready_o,
   output logic [N_OUP-1:0]         oup_valid_o,
   input  logic [N_OUP-1:0]         oup_ready_i,
   output logic [SEL_W-1:0]         oup_sel_o,
   input  logic [N_OUP-1:0]         cpl_i,
   output logic [N_OUP*CNT_W-1:0]   cnt_o,
   output logic                     idle_o,
   output logic                     cpl_err_o
);

   ctrl_state_e      state_q, state_d;
   logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             cpl_err_q;

   logic [N_OUP-1:0] avail, cnt_zero, cerr, hs;
   logic [SEL_W-1:0] pick_idx, grant;
   logic             pick_vld, gnt_vld;

   rr_pick #(.N(N_OUP), .SEL_W(SEL_W)) u_rr_pick (
      .req_i     (avail),
      .ptr_i     (rr_ptr_q),
      .gnt_idx_o (pick_idx),
      .gnt_vld_o (pick_vld)
   );

   always_comb begin
      grant   = pick_idx;
      gnt_vld = pick_vld;
      // Once locked, availability is ignored so valid stays on the same output.
      if (state_q == LOCKED) begin
         grant   = lock_idx_q;
         gnt_vld = 1'b1;
      end

      oup_valid_o = '0;
      inp_ready_o = 1'b0;
      oup_sel_o   = rr_ptr_q;
      if (gnt_vld) begin
         oup_sel_o          = grant;
         oup_valid_o[grant] = inp_valid_i;
         inp_ready_o        = oup_ready_i[grant];
      end
      hs = oup_valid_o & oup_ready_i;

      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      rr_ptr_d   = rr_ptr_q;
      case (state_q)
         UNLOCKED: begin
            if (inp_valid_i && gnt_vld && !oup_ready_i[grant]) begin
               state_d    = LOCKED;
               lock_idx_d = grant;
            end
         end
         LOCKED: begin
            if (hs[lock_idx_q]) state_d = UNLOCKED;
         end
         default: state_d = UNLOCKED;
      endcase
      if (|hs) rr_ptr_d = (grant == SEL_W'(N_OUP-1)) ? '0 : grant + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= UNLOCKED;
         lock_idx_q <= '0;
         rr_ptr_q   <= '0;
         cpl_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         rr_ptr_q   <= rr_ptr_d;
         cpl_err_q  <= cpl_err_q | (|cerr);
      end
   end

   for (genvar k = 0; k < N_OUP; k++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         case ({hs[k], cpl_i[k]})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end

      always_ff @(posedge clk_i) begin
         if (!rst_ni) cnt_q <= '0;
         else         cnt_q <= cnt_d;
      end

      assign avail[k]                  = (cnt_q != CNT_W'(MAX_OUTSTANDING));
      assign cnt_zero[k]               = (cnt_q == '0);
      assign cerr[k]                   = cpl_i[k] & ~hs[k] & cnt_zero[k];
      assign cnt_o[k*CNT_W +: CNT_W]   = cnt_q;
   end

   assign idle_o    = (&cnt_zero) & (state_q == UNLOCKED);
   assign cpl_err_o = cpl_err_q;

endmodule

// File: tb/tb_stream_demux_credit_ctrl.sv
// Randomized and directed bench for stream_demux_credit_ctrl against a queue/array-level reference model.
module tb_stream_demux_credit_ctrl;

   localparam int N   = 3;
   localparam int MAX = 4;
   localparam int CW  = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          inp_valid;
   logic          inp_ready;
   logic [N-1:0]  oup_valid;
   logic [N-1:0]  oup_ready;
   logic [1:0]    oup_sel;
   logic [N-1:0]  cpl;
   logic [N*CW-1:0] cnt_out;
   logic          idle;
   logic          cpl_err;

   stream_demux_credit_ctrl #(.N_OUP(N), .MAX_OUTSTANDING(MAX)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .inp_valid_i (inp_valid),
      .inp_ready_o (inp_ready),
      .oup_valid_o (oup_valid),
      .oup_ready_i (oup_ready),
      .oup_sel_o   (oup_sel),
      .cpl_i       (cpl),
      .cnt_o       (cnt_out),
      .idle_o      (idle),
      .cpl_err_o   (cpl_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int m_cnt[N];
   int m_ptr;
   bit m_lock;
   int m_lidx;
   bit m_err;

   logic [N-1:0]    last_valid;
   logic            last_ready;
   logic [1:0]      last_sel;
   logic [N*CW-1:0] last_cnt;
   logic            last_idle;
   logic            last_err;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [N-1:0] safe_cpl(input logic [N-1:0] m);
      logic [N-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) if (m[k] && m_cnt[k] > 0) r[k] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      m_ptr = 0; m_lock = 0; m_lidx = 0; m_err = 0;
   endtask

   // One clock cycle: drive, compare against the model, then advance the model.
   task automatic step(input logic v, input logic [N-1:0] rdy, input logic [N-1:0] c, input logic rst);
      bit              gv;
      int              g;
      logic [N-1:0]    e_valid, e_hs;
      logic            e_ready;
      logic [N*CW-1:0] e_cnt;
      bit              all_zero;
      @(negedge clk);
      inp_valid = v; oup_ready = rdy; cpl = c; rst_n = rst;
      #1;
      gv = 0; g = m_ptr;
      if (m_lock) begin
         gv = 1; g = m_lidx;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!gv && m_cnt[(m_ptr + i) % N] < MAX) begin
               gv = 1; g = (m_ptr + i) % N;
            end
         end
      end
      e_valid = '0; e_ready = 1'b0;
      if (gv) begin
         e_valid[g] = v;
         e_ready    = rdy[g];
      end
      e_cnt = '0; all_zero = 1;
      for (int k = 0; k < N; k++) begin
         e_cnt[k*CW +: CW] = CW'(m_cnt[k]);
         if (m_cnt[k] != 0) all_zero = 0;
      end
      last_valid = oup_valid; last_ready = inp_ready; last_sel = oup_sel;
      last_cnt = cnt_out; last_idle = idle; last_err = cpl_err;
      check_val("valid", 32'(oup_valid), 32'(e_valid));
      check_val("ready", 32'(inp_ready), 32'(e_ready));
      check_val("sel",   32'(oup_sel),   32'(g));
      check_val("cnt",   32'(cnt_out),   32'(e_cnt));
      check_val("idle",  32'(idle),      32'(all_zero && !m_lock));
      check_val("err",   32'(cpl_err),   32'(m_err));

      if (!rst) begin
         model_reset();
      end else begin
         e_hs = e_valid & rdy;
         for (int k = 0; k < N; k++) begin
            if (e_hs[k] && !c[k]) m_cnt[k]++;
            else if (c[k] && !e_hs[k]) begin
               if (m_cnt[k] == 0) m_err = 1;
               else m_cnt[k]--;
            end
         end
         if (m_lock) begin
            if (e_hs[m_lidx]) m_lock = 0;
         end else if (v && gv && !rdy[g]) begin
            m_lock = 1; m_lidx = g;
         end
         if (|e_hs) m_ptr = (g + 1) % N;
      end
      @(posedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (m_cnt[0] + m_cnt[1] + m_cnt[2] == 0) break;
         step(1'b0, '0, safe_cpl('1), 1'b1);
      end
      check_val("drained", 32'(m_cnt[0] + m_cnt[1] + m_cnt[2]), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; inp_valid = 1'b0; oup_ready = '0; cpl = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_valid", 32'(oup_valid), 32'd0);
      check_val("rst_ready", 32'(inp_ready), 32'd0);
      check_val("rst_sel",   32'(oup_sel),   32'd0);
      check_val("rst_idle",  32'(idle),      32'd1);
      check_val("rst_cnt",   32'(cnt_out),   32'd0);
      check_val("rst_err",   32'(cpl_err),   32'd0);

      // Plain round robin with every output ready.
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 3'b111, 3'b000, 1'b1);
         check_val("rr_seq", 32'(last_sel), 32'(i % 3));
         check_val("rr_ready", 32'(last_ready), 32'd1);
      end
      step(1'b0, 3'b000, 3'b000, 1'b1);
      check_val("cnt_222", 32'(last_cnt), 32'o222);
      drain();

      // Stall on output 0 must hold valid there until accepted.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 3'b000, 3'b000, 1'b1);
         check_val("lock_valid", 32'(last_valid), 32'b001);
         check_val("lock_sel", 32'(last_sel), 32'd0);
      end
      step(1'b1, 3'b001, 3'b000, 1'b1);
      check_val("lock_hs", 32'(last_ready), 32'd1);
      check_val("rr_ptr", 32'(m_ptr), 32'd1);
      drain();

      // Output 1 fills while 0 and 2 are kept drained; then one completion reopens it.
      for (int i = 0; i < 16; i++) step(1'b1, 3'b111, safe_cpl(3'b101), 1'b1);
      check_val("fill1", 32'(m_cnt[1]), 32'(MAX));
      step(1'b0, 3'b000, 3'b010, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 3'b111, safe_cpl(3'b101), 1'b1);
      drain();

      // All outputs full: no grant until a completion arrives.
      for (int i = 0; i < 20; i++) begin
         if (m_cnt[0] == MAX && m_cnt[1] == MAX && m_cnt[2] == MAX) break;
         step(1'b1, 3'b111, 3'b000, 1'b1);
      end
      step(1'b1, 3'b111, 3'b000, 1'b1);
      check_val("full_valid", 32'(last_valid), 32'd0);
      check_val("full_ready", 32'(last_ready), 32'd0);
      step(1'b1, 3'b111, 3'b100, 1'b1);
      step(1'b1, 3'b111, 3'b000, 1'b1);
      check_val("reopen_sel", 32'(last_sel), 32'd2);
      check_val("reopen_valid", 32'(last_valid), 32'b100);
      drain();

      // Randomized traffic with legal completions.
      for (int i = 0; i < 1500; i++) begin
         logic [N-1:0] cm;
         cm = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 7)) : '0;
         step(($urandom_range(0, 3) != 0), N'($urandom_range(0, 7)), safe_cpl(cm), 1'b1);
      end
      check_val("rand_err", 32'(last_err), 32'd0);
      drain();

      // Completion with nothing outstanding sets the sticky error.
      step(1'b0, 3'b000, 3'b001, 1'b1);
      step(1'b0, 3'b000, 3'b000, 1'b1);
      check_val("err_set", 32'(last_err), 32'd1);
      check_val("err_cnt0", 32'(last_cnt), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 3'b111, 3'b000, 1'b1);
      check_val("err_sticky", 32'(last_err), 32'd1);

      // Reset while locked with traffic outstanding.
      step(1'b1, 3'b000, 3'b000, 1'b1);
      step(1'b1, 3'b000, 3'b000, 1'b0);
      step(1'b0, 3'b000, 3'b000, 1'b1);
      check_val("mrst_valid", 32'(last_valid), 32'd0);
      check_val("mrst_cnt",   32'(last_cnt),   32'd0);
      check_val("mrst_idle",  32'(last_idle),  32'd1);
      check_val("mrst_sel",   32'(last_sel),   32'd0);
      check_val("mrst_err",   32'(last_err),   32'd0);
      step(1'b0, 3'b000, 3'b010, 1'b1);
      step(1'b0, 3'b000, 3'b000, 1'b1);
      check_val("late_cpl_err", 32'(last_err), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
